// File: rtl/tqvp_byte_pulse_gen.sv
// TinyQV byte peripheral with up to four 2A03-style pulse channels.
// Each channel has a period timer, an 8-step duty sequencer, an enable and a length counter.
module tqvp_byte_pulse_gen #(
  parameter int NUM_CH     = 4,
  parameter int TIMER_W    = 11,
  parameter int PRESCALE   = 1,
  parameter int MIN_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HI_W = TIMER_W - 8;

  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_PLO  = 2'd1;
  localparam logic [1:0] SEL_PHI  = 2'd2;
  localparam logic [1:0] SEL_LEN  = 2'd3;

  // Bit n of the returned pattern is the output level during sequencer step n.
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    case (duty)
      2'd0:    pat = 8'b0000_0010;
      2'd1:    pat = 8'b0000_0110;
      2'd2:    pat = 8'b0001_1110;
      2'd3:    pat = 8'b1111_1001;
      default: pat = 8'b0000_0000;
    endcase
    return pat[step];
  endfunction

  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic [1:0]    sel_s;
  logic [4:0]    rd_idx_s;
  logic [31:0]   ctrl_bus_s;
  logic [31:0]   plo_bus_s;
  logic [31:0]   phi_bus_s;
  logic [31:0]   len_bus_s;
  logic [3:0]    pulse_s;
  logic [3:0]    active_s;
  logic          unused_s;

  assign unused_s = ^ui_in;
  assign sel_s    = address[1:0];
  assign rd_idx_s = {address[3:2], 3'b000};
  assign tick_s   = (presc_r == PW'(PRESCALE - 1));

  // Global prescaler shared by all channel timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  for (genvar i = 0; i < 4; i++) begin : ch_g
    if (i < NUM_CH) begin : impl_g
      logic [1:0]         duty_r;
      logic               enable_r;
      logic               halt_r;
      logic [TIMER_W-1:0] period_r;
      logic [TIMER_W-1:0] timer_r;
      logic [2:0]         step_r;
      logic [7:0]         length_r;
      logic               hit_s;

      assign hit_s = data_write && (address[3:2] == 2'(i));

      // Register writes, restart and the timer/sequencer/length advance.
      // A LENGTH write takes priority over any same-edge decrement or advance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          duty_r   <= 2'd0;
          enable_r <= 1'b0;
          halt_r   <= 1'b0;
          period_r <= {TIMER_W{1'b0}};
          timer_r  <= {TIMER_W{1'b0}};
          step_r   <= 3'd0;
          length_r <= 8'd0;
        end else begin
          if (hit_s && (sel_s == SEL_CTRL)) begin
            duty_r   <= data_in[7:6];
            enable_r <= data_in[5];
            halt_r   <= data_in[4];
          end
          if (hit_s && (sel_s == SEL_PLO)) begin
            period_r[7:0] <= data_in;
          end
          if (hit_s && (sel_s == SEL_PHI)) begin
            period_r[TIMER_W-1:8] <= data_in[HI_W-1:0];
          end
          if (hit_s && (sel_s == SEL_LEN)) begin
            length_r <= data_in;
            step_r   <= 3'd0;
            timer_r  <= period_r;
          end else if (!enable_r) begin
            step_r  <= 3'd0;
            timer_r <= period_r;
          end else if (tick_s) begin
            if (timer_r == {TIMER_W{1'b0}}) begin
              timer_r <= period_r;
              step_r  <= step_r + 3'd1;
              if ((step_r == 3'd7) && !halt_r && (length_r != 8'd0)) begin
                length_r <= length_r - 8'd1;
              end
            end else begin
              timer_r <= timer_r - TIMER_W'(1);
            end
          end
        end
      end

      assign active_s[i] = enable_r & (halt_r | (length_r != 8'd0))
                         & (period_r >= TIMER_W'(MIN_PERIOD));
      assign pulse_s[i]  = active_s[i] & duty_bit(duty_r, step_r);

      assign ctrl_bus_s[i*8 +: 8] = {duty_r, enable_r, halt_r, 4'b0000};
      assign plo_bus_s[i*8 +: 8]  = period_r[7:0];
      assign phi_bus_s[i*8 +: 8]  = 8'(period_r[TIMER_W-1:8]);
      assign len_bus_s[i*8 +: 8]  = length_r;
    end else begin : none_g
      assign active_s[i]          = 1'b0;
      assign pulse_s[i]           = 1'b0;
      assign ctrl_bus_s[i*8 +: 8] = 8'h00;
      assign plo_bus_s[i*8 +: 8]  = 8'h00;
      assign phi_bus_s[i*8 +: 8]  = 8'h00;
      assign len_bus_s[i*8 +: 8]  = 8'h00;
    end
  end

  assign uo_out = {active_s, pulse_s};

  // Combinational readback of the addressed register; absent channels read zero.
  always_comb begin
    data_out = 8'h00;
    case (sel_s)
      SEL_CTRL: data_out = ctrl_bus_s[rd_idx_s +: 8];
      SEL_PLO:  data_out = plo_bus_s[rd_idx_s +: 8];
      SEL_PHI:  data_out = phi_bus_s[rd_idx_s +: 8];
      SEL_LEN:  data_out = len_bus_s[rd_idx_s +: 8];
      default:  data_out = 8'h00;
    endcase
  end

endmodule
